contador_modulo: RTL and testbench
==================================

// Module: contador_modulo
// PURPOSE
// - Parametrised modulo-N time-unit counter with up/down count, parallel load and an edit mode.
// - One instance per clock digit group (seconds, minutes, hours), chained through carry_o->inc_i and borrow_o->dec_i.
// - Replaces the fixed 0..59 minute stage; also serves 0..23 and 0..99 stages.
// PARAMETERS
// - MODULO  60                    count range 0..MODULO-1; 2 <= MODULO <= 2**WIDTH
// - WIDTH   $clog2(MODULO)        width of count and load value
// - START   0                     reset value of count; 0 <= START < MODULO
// PORTS
// - clk_i       in   1      clock
// - rstn_i      in   1      reset, asynchronous, active-low
// - inc_i       in   1      increment request, 1-cycle pulse (from lower stage or set button)
// - dec_i       in   1      decrement request, 1-cycle pulse
// - load_i      in   1      parallel load strobe
// - load_val_i  in   WIDTH  value captured when load_i=1
// - edit_i      in   1      level; 1 requests EDIT mode (time setting)
// - valor_o     out  WIDTH  current count (registered)
// - carry_o     out  1      1-cycle pulse on wrap MODULO-1 -> 0 (RUN only)
// - borrow_o    out  1      1-cycle pulse on wrap 0 -> MODULO-1 (RUN only)
// - editing_o   out  1      1 while FSM is in EDIT
// - dezena_o    out  4      BCD tens of valor_o (CONTADOR_BCD_EN only)
// - unidade_o   out  4      BCD units of valor_o (CONTADOR_BCD_EN only)
// BEHAVIOUR
// - Reset: valor_o=START, carry_o=0, borrow_o=0, editing_o=0, FSM=RUN; all registers async-cleared.
// - FSM: RUN -> EDIT when edit_i=1 at clk edge; EDIT -> RUN when edit_i=0; editing_o is the registered state.
// - Per-cycle priority: load_i > (inc_i & dec_i: no change, no pulse) > inc_i > dec_i > hold.
// - Load: valor <= load_val_i; if load_val_i >= MODULO, valor <= MODULO-1 (saturate). No carry/borrow on load.
// - inc: valor==MODULO-1 -> valor<=0 and carry_o=1 next cycle (RUN); else valor+1.
// - dec: valor==0 -> valor<=MODULO-1 and borrow_o=1 next cycle (RUN); else valor-1.
// - Latency: valor_o, carry_o, borrow_o all update on the same clk edge that samples the request (1 cycle).
// - carry_o/borrow_o default 0 every cycle; never both 1; never high for 2 consecutive cycles unless the wrap request repeats.
// - EDIT: inc/dec wrap identically but carry_o/borrow_o stay 0 (setting one field never disturbs the next).
// - Mode change in the same cycle as inc_i: request evaluated in the state held before the edge.
// - Arithmetic in WIDTH bits; no intermediate overflow when MODULO == 2**WIDTH (compare before add).
// - Reset mid-operation: pending pulses dropped, valor_o returns to START immediately (async).
// CONFIGURATION
// - Macro CONTADOR_BCD_EN defined: dezena_o/unidade_o ports exist; combinational from valor_o
//   (dezena=valor/10, unidade=valor%10); zero latency; requires MODULO <= 100 (elaboration $error otherwise).
// - Macro undefined: ports absent, no divider logic; all other behaviour identical.
// TESTING
// - MODULO=60: reset, 60 inc pulses -> valor 0..59 then 0; carry_o=1 exactly once, same cycle valor_o becomes 0.
// - MODULO=24, valor=0, dec_i pulse -> valor_o=23, borrow_o=1 one cycle; second dec -> 22, borrow_o=0.
// - load_i with load_val_i=45 (MODULO=60) -> 45; load_val_i=63 -> 59; load+inc same cycle -> loaded value, no carry.
// - edit_i=1, valor=59, inc -> valor 0, carry_o=0, editing_o=1; edit_i=0 then inc at 59 -> carry_o=1.
// - inc_i & dec_i together at 59 -> valor stays 59, no pulse; rstn_i low mid-count (valor 37) -> valor START=0 async.
// - CONTADOR_BCD_EN, MODULO=60, load 47 -> dezena_o=4, unidade_o=7; MODULO=100 sweep 0..99 matches BCD.

Source files
------------

// File: rtl/contador_modulo.sv
// contador_modulo: modulo-N up/down time-unit counter with load, edit mode and chained carry/borrow.
// Optional BCD outputs dezena_o/unidade_o when CONTADOR_BCD_EN is defined.
module contador_modulo #(
  parameter int MODULO = 60,
  parameter int WIDTH  = $clog2(MODULO),
  parameter int START  = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             edit_i,
  output logic [WIDTH-1:0] valor_o,
  output logic             carry_o,
  output logic             borrow_o,
  output logic             editing_o
`ifdef CONTADOR_BCD_EN
  ,
  output logic [3:0]       dezena_o,
  output logic [3:0]       unidade_o
`endif
);
  typedef enum logic {RUN, EDIT} state_t;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   LIM = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] RST = WIDTH'(START);
  if (MODULO < 2 || MODULO > 2 ** WIDTH || START < 0 || START >= MODULO) begin : g_bad_param
    $error("contador_modulo: invalid MODULO/WIDTH/START");
  end
  state_t           r_state;
  logic [WIDTH-1:0] r_valor;
  logic             r_carry;
  logic             r_borrow;
  logic             w_sat;
  logic             w_up;
  logic             w_dn;
  assign w_sat = {1'b0, load_val_i} >= LIM;
  assign w_up  = inc_i & ~dec_i;
  assign w_dn  = dec_i & ~inc_i;
  // Wrap tests compare against MAX/0 before stepping so MODULO == 2**WIDTH never overflows.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= RUN;
      r_valor  <= RST;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= edit_i ? EDIT : RUN;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      if (load_i) begin
        r_valor <= w_sat ? MAX : load_val_i;
      end else if (w_up) begin
        r_valor <= (r_valor == MAX) ? '0 : r_valor + WIDTH'(1);
        r_carry <= (r_valor == MAX) && (r_state == RUN);
      end else if (w_dn) begin
        r_valor  <= (r_valor == '0) ? MAX : r_valor - WIDTH'(1);
        r_borrow <= (r_valor == '0) && (r_state == RUN);
      end
    end
  end
  assign valor_o   = r_valor;
  assign carry_o   = r_carry;
  assign borrow_o  = r_borrow;
  assign editing_o = (r_state == EDIT);
`ifdef CONTADOR_BCD_EN
  if (MODULO > 100) begin : g_bad_bcd
    $error("contador_modulo: CONTADOR_BCD_EN requires MODULO <= 100");
  end
  logic [7:0] w_v;
  assign w_v       = 8'(r_valor);
  assign dezena_o  = 4'(w_v / 8'd10);
  assign unidade_o = 4'(w_v % 8'd10);
`endif
endmodule

// File: tb/tb_contador_modulo.sv
// tb_contador_modulo: directed checks of contador_modulo (MODULO=60 and 24, plus 100 with BCD).
module tb_contador_modulo;
  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       inc, dec, load, edit;
  logic [5:0] lv;
  logic [5:0] valor;
  logic       carry, borrow, editing;
  logic       inc24, dec24;
  logic [4:0] valor24;
  logic       carry24, borrow24, editing24;
  int         n_chk = 0;
  int         n_err = 0;
  always #5 clk_i = ~clk_i;
`ifdef CONTADOR_BCD_EN
  logic [3:0] dez, uni, dez100, uni100;
  logic       inc100;
  logic [6:0] valor100;
  logic       carry100, borrow100, editing100;
  contador_modulo #(.MODULO(100)) u100 (
    .clk_i(clk_i), .rstn_i(rstn_i), .inc_i(inc100), .dec_i(1'b0), .load_i(1'b0),
    .load_val_i(7'd0), .edit_i(1'b0), .valor_o(valor100), .carry_o(carry100),
    .borrow_o(borrow100), .editing_o(editing100), .dezena_o(dez100), .unidade_o(uni100)
  );
`endif
  contador_modulo #(.MODULO(60)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .inc_i(inc), .dec_i(dec), .load_i(load),
    .load_val_i(lv), .edit_i(edit), .valor_o(valor), .carry_o(carry),
    .borrow_o(borrow), .editing_o(editing)
`ifdef CONTADOR_BCD_EN
    , .dezena_o(dez), .unidade_o(uni)
`endif
  );
  contador_modulo #(.MODULO(24)) u24 (
    .clk_i(clk_i), .rstn_i(rstn_i), .inc_i(inc24), .dec_i(dec24), .load_i(1'b0),
    .load_val_i(5'd0), .edit_i(1'b0), .valor_o(valor24), .carry_o(carry24),
    .borrow_o(borrow24), .editing_o(editing24)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    rstn_i = 1'b0;
    {inc, dec, load, edit, inc24, dec24} = '0;
    lv = '0;
`ifdef CONTADOR_BCD_EN
    inc100 = 1'b0;
`endif
    #3;
    chk("rst_valor", valor, 0);
    chk("rst_carry", carry, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_editing", editing, 0);
    chk("rst_valor24", valor24, 0);
    #10 rstn_i = 1'b1;
    dec24 = 1'b1;
    step();
    chk("m24_dec_wrap", valor24, 23);
    chk("m24_borrow", borrow24, 1);
    chk("m24_carry", carry24, 0);
    step();
    chk("m24_dec2", valor24, 22);
    chk("m24_borrow2", borrow24, 0);
    dec24 = 1'b0;
    inc = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      chk($sformatf("inc_valor_%0d", i), valor, i % 60);
      chk($sformatf("inc_carry_%0d", i), carry, (i == 60) ? 1 : 0);
    end
    inc = 1'b0;
    step();
    chk("carry_drop", carry, 0);
    chk("hold_valor", valor, 0);
    load = 1'b1; lv = 6'd45;
    step();
    chk("load45", valor, 45);
    lv = 6'd63;
    step();
    chk("load63_sat", valor, 59);
    lv = 6'd59; inc = 1'b1;
    step();
    chk("load_inc_valor", valor, 59);
    chk("load_inc_carry", carry, 0);
    load = 1'b0; dec = 1'b1;
    step();
    chk("incdec_valor", valor, 59);
    chk("incdec_carry", carry, 0);
    chk("incdec_borrow", borrow, 0);
    {inc, dec} = '0; edit = 1'b1;
    step();
    chk("edit_enter", editing, 1);
    inc = 1'b1;
    step();
    chk("edit_inc_valor", valor, 0);
    chk("edit_inc_carry", carry, 0);
    chk("edit_inc_editing", editing, 1);
    inc = 1'b0; load = 1'b1; lv = 6'd59;
    step();
    load = 1'b0; edit = 1'b0; inc = 1'b1;
    step();
    chk("exit_inc_valor", valor, 0);
    chk("exit_inc_carry", carry, 0);
    chk("exit_editing", editing, 0);
    inc = 1'b0; load = 1'b1;
    step();
    load = 1'b0; inc = 1'b1;
    step();
    chk("run_inc_valor", valor, 0);
    chk("run_inc_carry", carry, 1);
    inc = 1'b0; dec = 1'b1;
    step();
    chk("run_dec_valor", valor, 59);
    chk("run_dec_borrow", borrow, 1);
    chk("run_dec_carry", carry, 0);
    dec = 1'b0;
    step();
    chk("borrow_drop", borrow, 0);
    edit = 1'b1; load = 1'b1; lv = 6'd0;
    step();
    load = 1'b0; dec = 1'b1;
    step();
    chk("edit_dec_valor", valor, 59);
    chk("edit_dec_borrow", borrow, 0);
    dec = 1'b0; edit = 1'b0;
    step();
    chk("edit_leave", editing, 0);
`ifdef CONTADOR_BCD_EN
    load = 1'b1; lv = 6'd47;
    step();
    chk("bcd_dez47", dez, 4);
    chk("bcd_uni47", uni, 7);
    load = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("bcd100_dez_%0d", i), dez100, i / 10);
      chk($sformatf("bcd100_uni_%0d", i), uni100, i % 10);
      inc100 = 1'b1;
      step();
    end
    inc100 = 1'b0;
    chk("bcd100_wrap", valor100, 0);
`endif
    load = 1'b1; lv = 6'd37;
    step();
    load = 1'b0;
    chk("load37", valor, 37);
    #2 rstn_i = 1'b0;
    #1;
    chk("async_rst_valor", valor, 0);
    #2 rstn_i = 1'b1;
    load = 1'b1; lv = 6'd59;
    step();
    load = 1'b0; inc = 1'b1;
    step();
    inc = 1'b0;
    chk("pre_rst_carry", carry, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_drops_carry", carry, 0);
    chk("rst_valor2", valor, 0);
    #2 rstn_i = 1'b1;
    step();
    chk("post_rst_hold", valor, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
